// File: rtl/snake_body.sv
// Snake segment store and movement engine: steps the head once per tick, grows on
// eat, streams all segments head-first and flags wall or self collision.
module snake_body #(
  parameter int                         H_LOGIC_WIDTH = 5,
  parameter int                         V_LOGIC_WIDTH = 5,
  parameter logic [H_LOGIC_WIDTH-1:0]   H_LOGIC_MAX   = 5'd31,
  parameter logic [V_LOGIC_WIDTH-1:0]   V_LOGIC_MAX   = 5'd23,
  parameter int                         MAX_LEN       = 64,
  parameter int                         INIT_LEN      = 3,
  parameter logic [23:0]                TICK_DIV      = 24'd5000000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               dir_in,
  input  logic                     dir_vld,
  input  logic                     is_eat,
  output logic [H_LOGIC_WIDTH-1:0] x_snake_cur,
  output logic [V_LOGIC_WIDTH-1:0] y_snake_cur,
  output logic [9:0]               length,
  output logic                     vld_start,
  output logic                     vld,
  output logic                     vld_t,
  output logic                     is_end,
  output logic                     game_over
);

  localparam int PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {S_IDLE, S_STEP, S_START, S_STREAM, S_CHECK, S_DEAD} state_t;

  state_t                   state_q, state_d;
  logic [23:0]              cnt_q;
  logic                     tick;
  logic [PW-1:0]            hp_q, hp_dec, seg_idx;
  logic [10:0]              idx_sum;
  logic [9:0]               k_q, len_q;
  logic [1:0]               dir_q, next_dir_q, dir_ref;
  logic                     grow_q, hit_q, over_q;
  logic                     wall, seg_hit;
  logic [H_LOGIC_WIDTH-1:0] mem_x [MAX_LEN];
  logic [V_LOGIC_WIDTH-1:0] mem_y [MAX_LEN];
  logic [H_LOGIC_WIDTH-1:0] head_x, new_x, seg_x;
  logic [V_LOGIC_WIDTH-1:0] head_y, new_y, seg_y;

  assign tick    = (cnt_q == TICK_DIV - 24'd1);
  assign head_x  = mem_x[hp_q];
  assign head_y  = mem_y[hp_q];
  assign hp_dec  = (hp_q == '0) ? PW'(MAX_LEN - 1) : hp_q - 1'b1;
  // segment k lives at (hp + k) mod MAX_LEN
  assign idx_sum = 11'(hp_q) + {1'b0, k_q};
  assign seg_idx = (idx_sum >= 11'(MAX_LEN)) ? PW'(idx_sum - 11'(MAX_LEN)) : PW'(idx_sum);
  assign seg_x   = mem_x[seg_idx];
  assign seg_y   = mem_y[seg_idx];
  assign seg_hit = (k_q != '0) && (seg_x == head_x) && (seg_y == head_y);
  // during STEP the pending direction is what gets committed, so reversal is judged against it
  assign dir_ref = (state_q == S_STEP) ? next_dir_q : dir_q;

  always_comb begin
    new_x = head_x;
    new_y = head_y;
    wall  = 1'b0;
    case (next_dir_q)
      2'b00:   begin wall = (head_y == '0);          new_y = head_y - 1'b1; end
      2'b01:   begin wall = (head_x == H_LOGIC_MAX); new_x = head_x + 1'b1; end
      2'b10:   begin wall = (head_y == V_LOGIC_MAX); new_y = head_y + 1'b1; end
      default: begin wall = (head_x == '0);          new_x = head_x - 1'b1; end
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (tick && !over_q) state_d = S_STEP;
      S_STEP:   state_d = wall ? S_DEAD : S_START;
      S_START:  state_d = S_STREAM;
      S_STREAM: if (k_q == len_q - 10'd1) state_d = S_CHECK;
      S_CHECK:  state_d = hit_q ? S_DEAD : S_IDLE;
      S_DEAD:   state_d = S_DEAD;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      hp_q       <= '0;
      k_q        <= '0;
      len_q      <= 10'(INIT_LEN);
      dir_q      <= 2'b01;
      next_dir_q <= 2'b01;
      grow_q     <= 1'b0;
      hit_q      <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= tick ? '0 : cnt_q + 24'd1;
      if (dir_vld && (dir_in != (dir_ref ^ 2'b10))) next_dir_q <= dir_in;
      // an eat seen during STEP belongs to the following step
      if (state_q == S_STEP) grow_q <= is_eat;
      else if (is_eat)       grow_q <= 1'b1;
      case (state_q)
        S_STEP: begin
          dir_q <= next_dir_q;
          if (wall) over_q <= 1'b1;
          else begin
            hp_q <= hp_dec;
            if (grow_q && (len_q < 10'(MAX_LEN))) len_q <= len_q + 10'd1;
          end
        end
        S_START:  k_q <= '0;
        S_STREAM: begin
          k_q <= k_q + 10'd1;
          if (seg_hit) hit_q <= 1'b1;
        end
        S_CHECK: begin
          hit_q <= 1'b0;
          if (hit_q) over_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        mem_x[i] <= (i < INIT_LEN) ? H_LOGIC_WIDTH'(INIT_LEN - 1 - i) : '0;
        mem_y[i] <= '0;
      end
    end else if (state_q == S_STEP && !wall) begin
      mem_x[hp_dec] <= new_x;
      mem_y[hp_dec] <= new_y;
    end
  end

  assign vld_start   = (state_q == S_START);
  assign vld         = (state_q == S_STREAM);
  assign vld_t       = (state_q == S_CHECK);
  assign is_end      = (state_q == S_CHECK);
  assign x_snake_cur = vld ? seg_x : '0;
  assign y_snake_cur = vld ? seg_y : '0;
  assign length      = len_q;
  assign game_over   = over_q;

endmodule

// File: tb/tb_snake_body.sv
// Bench for snake_body: a queue-based snake model predicts every stream, growth and death.
module tb_snake_body;
  localparam int TD = 12;
  localparam int ML = 8;

  typedef struct packed { logic [4:0] x; logic [4:0] y; } pt_t;

  logic       clk = 1'b0, rst = 1'b1;
  logic [1:0] dir_in = 2'd0;
  logic       dir_vld = 1'b0, is_eat = 1'b0;
  logic [4:0] x_snake_cur, y_snake_cur;
  logic [9:0] length;
  logic       vld_start, vld, vld_t, is_end, game_over;

  snake_body #(.H_LOGIC_WIDTH(5), .V_LOGIC_WIDTH(5), .H_LOGIC_MAX(5'd31), .V_LOGIC_MAX(5'd23),
               .MAX_LEN(ML), .INIT_LEN(3), .TICK_DIV(24'(TD))) dut (
    .clk(clk), .rst(rst), .dir_in(dir_in), .dir_vld(dir_vld), .is_eat(is_eat),
    .x_snake_cur(x_snake_cur), .y_snake_cur(y_snake_cur), .length(length),
    .vld_start(vld_start), .vld(vld), .vld_t(vld_t), .is_end(is_end), .game_over(game_over));

  always #5 clk = ~clk;

  // posedges since reset release
  int cyc = 0;
  always @(posedge clk or negedge rst) if (!rst) cyc <= 0; else cyc <= cyc + 1;

  int vectors = 0, fails = 0;

  pt_t body[$];
  int  m_dir, m_next, m_steps;
  bit  m_grow, m_go;

  pt_t cap[$];
  bit  cap_got, cap_tok, cap_lenbad;
  int  cap_start, cap_len;

  function automatic void m_reset();
    pt_t p;
    body.delete();
    for (int i = 0; i < 3; i++) begin p.x = 5'(2 - i); p.y = 5'd0; body.push_back(p); end
    m_dir = 1; m_next = 1; m_steps = 0; m_grow = 0; m_go = 0;
  endfunction

  function automatic void m_dirreq(int d);
    if (d != (m_dir + 2) % 4) m_next = d;
  endfunction

  // returns 1 when the step runs into a wall
  function automatic bit m_step();
    int  nx, ny;
    pt_t p;
    bit  grow;
    m_steps++;
    m_dir = m_next;
    nx = int'(body[0].x); ny = int'(body[0].y);
    case (m_dir) 0: ny--; 1: nx++; 2: ny++; default: nx--; endcase
    if (nx < 0 || nx > 31 || ny < 0 || ny > 23) begin m_go = 1; return 1'b1; end
    grow = m_grow && (body.size() < ML);
    p.x = 5'(nx); p.y = 5'(ny);
    body.push_front(p);
    if (!grow) void'(body.pop_back());
    m_grow = 0;
    for (int i = 1; i < body.size(); i++) if (body[i] == p) m_go = 1;
    return 1'b0;
  endfunction

  // bit mask of disagreements between captured stream and model
  function automatic int stream_diff();
    int d = 0;
    if (!cap_got || cap_start != m_steps * TD + 1) d |= 1;
    if (cap.size() != body.size()) d |= 2;
    else for (int i = 0; i < cap.size(); i++) if (cap[i] !== body[i]) d |= 2;
    if (cap_len != body.size() || cap_lenbad) d |= 4;
    if (!cap_tok) d |= 8;
    return d;
  endfunction

  task automatic get_stream();
    bit fok = 1;
    cap.delete(); cap_got = 0; cap_tok = 0; cap_lenbad = 0; cap_start = -1; cap_len = -1;
    for (int i = 0; i < 2 * TD + 4; i++) begin
      @(negedge clk);
      if (vld_start === 1'b1) begin cap_got = 1; cap_start = cyc; break; end
    end
    if (!cap_got) return;
    if (vld !== 1'b0 || x_snake_cur !== 5'd0 || y_snake_cur !== 5'd0) fok = 0;
    for (int i = 0; i < ML + 2; i++) begin
      @(negedge clk);
      if (vld !== 1'b1) break;
      cap.push_back(pt_t'({x_snake_cur, y_snake_cur}));
      if (cap_len < 0) cap_len = int'(length); else if (int'(length) != cap_len) cap_lenbad = 1;
      if (vld_start !== 1'b0 || vld_t !== 1'b0) fok = 0;
    end
    cap_tok = fok && vld_t === 1'b1 && is_end === 1'b1 && vld_start === 1'b0 &&
              x_snake_cur === 5'd0 && y_snake_cur === 5'd0;
  endtask

  task automatic pulse(input bit dv, input logic [1:0] d, input bit eat);
    dir_in = d; dir_vld = dv; is_eat = eat;
    if (dv) m_dirreq(int'(d));
    if (eat) m_grow = 1;
    @(negedge clk);
    dir_vld = 1'b0; is_eat = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; dir_vld = 1'b0; is_eat = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b0; #1;
    vectors++;
    if ({vld_start, vld, vld_t, is_end, game_over, x_snake_cur, y_snake_cur} !== 15'd0 || length !== 10'd3) begin
      fails++; $display("FAIL reset_outputs: flags/xy=%b len=%0d want 0/3",
        {vld_start, vld, vld_t, is_end, game_over, x_snake_cur, y_snake_cur}, length);
    end
    @(negedge clk); @(negedge clk); rst = 1'b1; m_reset();
    repeat (TD) @(negedge clk);
    vectors++;
    if ({vld_start, vld, vld_t} !== 3'b000) begin
      fails++; $display("FAIL reset_quiet: start/vld/t=%b want 000 at cyc %0d", {vld_start, vld, vld_t}, cyc);
    end
  endtask

  task automatic test_first_stream();
    int d;
    void'(m_step()); get_stream(); d = stream_diff();
    vectors++;
    if (d != 0) begin
      fails++; $display("FAIL first_stream: diff=%0d start=%0d want %0d n=%0d want %0d",
        d, cap_start, m_steps * TD + 1, cap.size(), body.size());
    end
    vectors++;
    if (game_over !== 1'b0 || length !== 10'd3 || cap.size() == 0 || cap[0] !== pt_t'({5'd3, 5'd0})) begin
      fails++; $display("FAIL first_head: go=%b len=%0d want 0/3 head=(3,0)", game_over, length);
    end
  endtask

  task automatic test_eat();
    int d;
    pulse(0, 2'd0, 1);
    void'(m_step()); get_stream(); d = stream_diff();
    vectors++;
    if (d != 0 || length !== 10'd4) begin
      fails++; $display("FAIL eat_grow: diff=%0d len=%0d want 4", d, length);
    end
    pulse(0, 2'd0, 1); pulse(0, 2'd0, 1);
    void'(m_step()); get_stream(); d = stream_diff();
    vectors++;
    if (d != 0 || length !== 10'd5) begin
      fails++; $display("FAIL eat_multi: diff=%0d len=%0d want 5", d, length);
    end
  endtask

  task automatic test_reverse();
    int d, hx, hy;
    hx = int'(body[0].x); hy = int'(body[0].y);
    pulse(1, 2'b11, 0);
    void'(m_step()); get_stream(); d = stream_diff();
    vectors++;
    if (d != 0 || cap.size() == 0 || int'(cap[0].x) != hx + 1 || int'(cap[0].y) != hy) begin
      fails++; $display("FAIL reverse_ignored: diff=%0d head_x=%0d want %0d", d,
        cap.size() ? int'(cap[0].x) : -1, hx + 1);
    end
    pulse(1, 2'b10, 0);
    void'(m_step()); get_stream(); d = stream_diff();
    vectors++;
    if (d != 0 || cap.size() == 0 || int'(cap[0].y) != hy + 1) begin
      fails++; $display("FAIL turn_down: diff=%0d head_y=%0d want %0d", d,
        cap.size() ? int'(cap[0].y) : -1, hy + 1);
    end
  endtask

  task automatic check_dead_quiet(input string nm);
    bit bad = 0;
    for (int i = 0; i < 3 * TD; i++) begin
      @(negedge clk);
      if (vld_start !== 1'b0 || vld !== 1'b0 || vld_t !== 1'b0 || game_over !== 1'b1) bad = 1;
    end
    vectors++;
    if (bad) begin fails++; $display("FAIL %s_dead_quiet: activity after death, go=%b", nm, game_over); end
  endtask

  task automatic test_wall();
    int d, nbad = 0, tgt;
    do_reset();
    for (int s = 0; s < 40 && body[0].x != 5'd31; s++) begin
      void'(m_step()); get_stream(); d = stream_diff();
      vectors++;
      if (d != 0) begin fails++; nbad++; $display("FAIL wall_run step %0d: diff=%0d", m_steps, d); end
    end
    vectors++;
    if (m_step() != 1'b1) begin fails++; $display("FAIL wall_setup: head x=%0d want 31", body[0].x); end
    tgt = m_steps * TD;
    for (int i = 0; i < 3 * TD && cyc < tgt; i++) @(negedge clk);
    vectors++;
    if (cyc != tgt || game_over !== 1'b0) begin
      fails++; $display("FAIL wall_pre: cyc=%0d want %0d go=%b want 0", cyc, tgt, game_over);
    end
    @(negedge clk);
    vectors++;
    if (game_over !== 1'b1 || vld_start !== 1'b0 || length !== 10'd3) begin
      fails++; $display("FAIL wall_over: go=%b start=%b len=%0d want 1/0/3", game_over, vld_start, length);
    end
    check_dead_quiet("wall");
  endtask

  task automatic test_self();
    int  d;
    bit  eat_t[5] = '{1, 1, 0, 0, 0};
    int  dir_t[5] = '{-1, -1, 2, 3, 0};
    do_reset();
    for (int s = 0; s < 5; s++) begin
      pulse(dir_t[s] >= 0, 2'(dir_t[s] < 0 ? 0 : dir_t[s]), eat_t[s]);
      void'(m_step()); get_stream(); d = stream_diff();
      vectors++;
      if (d != 0 || game_over !== 1'b0) begin
        fails++; $display("FAIL self_step %0d: diff=%0d go=%b want 0", s, d, game_over);
      end
    end
    @(negedge clk);
    vectors++;
    if (game_over !== 1'b1) begin fails++; $display("FAIL self_hit: go=%b want 1", game_over); end
    check_dead_quiet("self");
  endtask

  task automatic test_saturate();
    int d;
    do_reset();
    for (int s = 0; s < 7; s++) begin
      pulse(0, 2'd0, 1);
      void'(m_step()); get_stream(); d = stream_diff();
      vectors++;
      if (d != 0) begin fails++; $display("FAIL saturate step %0d: diff=%0d len=%0d", s, d, length); end
    end
    vectors++;
    if (length !== 10'(ML)) begin fails++; $display("FAIL saturate_len: len=%0d want %0d", length, ML); end
  endtask

  task automatic test_reset_midstream();
    int d;
    bit seen = 0;
    do_reset();
    for (int i = 0; i < 2 * TD; i++) begin
      @(negedge clk);
      if (vld_start === 1'b1) begin seen = 1; break; end
    end
    @(negedge clk); @(negedge clk);
    vectors++;
    if (!seen || vld !== 1'b1) begin fails++; $display("FAIL midstream_setup: seen=%0d vld=%b", seen, vld); end
    rst = 1'b0; #1;
    vectors++;
    if ({vld_start, vld, vld_t, is_end, game_over, x_snake_cur, y_snake_cur} !== 15'd0 || length !== 10'd3) begin
      fails++; $display("FAIL midstream_reset: flags/xy=%b len=%0d want 0/3",
        {vld_start, vld, vld_t, is_end, game_over, x_snake_cur, y_snake_cur}, length);
    end
    @(negedge clk); rst = 1'b1; m_reset();
    void'(m_step()); get_stream(); d = stream_diff();
    vectors++;
    if (d != 0) begin fails++; $display("FAIL midstream_restart: diff=%0d start=%0d", d, cap_start); end
  endtask

  task automatic test_random();
    int d, tgt;
    do_reset();
    for (int it = 0; it < 60; it++) begin
      pulse($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), $urandom_range(0, 2) == 0);
      if (m_step()) begin
        tgt = m_steps * TD;
        for (int i = 0; i < 3 * TD && cyc <= tgt; i++) @(negedge clk);
        vectors++;
        if (cyc != tgt + 1 || game_over !== 1'b1) begin
          fails++; $display("FAIL rand_wall it %0d: cyc=%0d want %0d go=%b", it, cyc, tgt + 1, game_over);
        end
        do_reset();
      end else begin
        get_stream(); d = stream_diff();
        vectors++;
        if (d != 0) begin fails++; $display("FAIL rand_step it %0d: diff=%0d len=%0d want %0d", it, d, length, body.size()); end
        if (m_go) begin
          @(negedge clk);
          vectors++;
          if (game_over !== 1'b1) begin fails++; $display("FAIL rand_self it %0d: go=%b want 1", it, game_over); end
          do_reset();
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_stream();
    test_eat();
    test_reverse();
    test_wall();
    test_self();
    test_saturate();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule

// File: doc/snake_body.md
# snake_body

Owns the snake's segment list and movement. On every game tick it advances the head one logical cell in the current direction. If an eat pulse arrived since the last step, it grows by one segment. It then streams every segment, head first, to the apple and collision logic downstream using a start/valid/terminate framing, and flags wall or self collision as game over.

## Interface
- H_LOGIC_WIDTH, 5, column coordinate width
- V_LOGIC_WIDTH, 5, row coordinate width
- H_LOGIC_MAX, 5'd31, last legal column
- V_LOGIC_MAX, 5'd23, last legal row
- MAX_LEN, 64, segment storage depth; length saturates here
- INIT_LEN, 3, length after reset (2..MAX_LEN)
- TICK_DIV, 24'd5000000, clk cycles per movement step (≥ MAX_LEN+4)
- clk  in  1  system clock; all logic on posedge
- rst  in  1  reset, asynchronous assert, active-low (0 = reset), synchronous release
- dir_in  in  2  requested direction: 00 up (y-1), 01 right (x+1), 10 down (y+1), 11 left (x-1)
- dir_vld  in  1  one-cycle strobe qualifying dir_in
- is_eat  in  1  pulse from apple logic: head is on the apple
- x_snake_cur  out  H_LOGIC_WIDTH  segment column during stream
- y_snake_cur  out  V_LOGIC_WIDTH  segment row during stream
- length  out  10  current segment count
- vld_start  out  1  one-cycle pulse: stream about to begin
- vld  out  1  x/y_snake_cur hold a valid segment
- vld_t  out  1  one-cycle pulse: stream finished
- is_end  out  1  one-cycle pulse, coincident with vld_t
- game_over  out  1  sticky; set on wall or self collision

## Operation
- Storage: circular buffer of MAX_LEN entries, head pointer hp. Segment k is at (hp+k) mod MAX_LEN. Pointer arithmetic wraps modulo MAX_LEN.
- Reset state:
  - head (INIT_LEN-1, 0), body extending left to (0, 0); direction right.
  - length = INIT_LEN; all outputs 0 except length.
  - Tick counter 0; grow_pending 0; state IDLE.
- Direction:
  - On dir_vld, dir_in is latched into next_dir unless it is the exact reverse of the committed direction. Reverse requests are ignored.
  - next_dir commits at each step. The last accepted strobe before the step wins.
- Eat: an is_eat pulse in any state sets grow_pending. It is cleared at the step that consumes it. Multiple pulses between steps give one growth.
- FSM: IDLE → STEP → START → STREAM → CHECK → IDLE. DEAD is terminal until reset.
  - IDLE: the tick counter counts to TICK_DIV-1, then wraps and raises tick. On tick with game_over=0, go to STEP.
  - STEP (1 cycle): compute the new head from the committed direction.
    - Wall test: x=0 moving left, x=H_LOGIC_MAX moving right, y=0 moving up, or y=V_LOGIC_MAX moving down sets game_over and goes to DEAD. No wrap; the buffer is unchanged.
    - Otherwise: hp ← hp-1 and the new head is written at hp.
    - If grow_pending and length<MAX_LEN, length increments; otherwise the tail is dropped implicitly.
    - grow_pending clears.
  - START (1 cycle): vld_start=1, vld=0.
  - STREAM (length cycles): vld=1; k-th cycle (k=0..length-1) drives segment k.
    - For k≥1, segment k is compared with the head; any match sets a self-hit flag.
  - CHECK (1 cycle): vld_t=1, is_end=1. If the self-hit flag is set, set game_over and go to DEAD; else go to IDLE. The flag clears.
  - DEAD: no streams, no ticks acted on; outputs hold 0 except length and game_over.
- A tick arriving outside IDLE is dropped; the counter keeps free-running.
- x/y_snake_cur hold 0 whenever vld=0.

## Timing
- Tick at cycle T (IDLE) → STEP at T+1 → vld_start at T+2 → vld at T+3..T+2+length → vld_t/is_end at T+3+length.
- length output updates at the STEP edge. It is stable throughout the stream and equals the number of vld cycles.
- is_eat during a stream is counted for the next step, never the current one.
- game_over is visible the cycle after STEP (wall) or after CHECK (self).
- Reset asserted mid-stream: outputs clear immediately (asynchronous). After release, the FSM starts in IDLE with the counter at 0. No vld_t is emitted for the aborted stream.
- Length saturation: at length=MAX_LEN with grow_pending, the step moves without growing and grow_pending clears.

## Test plan
- Reset and release; TICK_DIV=8 → first vld_start at cycle 9. Stream is (3,0),(2,0),(1,0); vld_t the cycle after; length=3; game_over=0.
- Pulse is_eat before the next tick → length=4; stream is (4,0),(3,0),(2,0),(1,0).
- Heading right, dir_vld with dir_in=11 (reverse) → ignored, next head x+1. Then dir_in=10 → next head y+1.
- Drive right until head x=31, one more tick → game_over=1 at the STEP+1 cycle; no further vld_start ever.
- Grow to length 5, then steer down, left, up into the body → game_over set at the CHECK cycle with vld_t.
- Pull rst low during STREAM → all outputs 0 within the cycle; after release, length=3 and the first stream has the reset coordinates.
